// File: rtl/dircc_rts_send_scheduler.sv
// ============================================================================
// dircc_rts_send_scheduler
//
// Purpose:
//   Consumes the per-port rts_ready flags produced by the RTS handler and
//   issues one send request at a time to the device send handler. Asserted
//   flags are served round-robin. After each send completes (or times out),
//   the scheduler holds off for a few cycles. This gives the registered
//   rts_ready time to reflect the updated device state before it is sampled
//   again.
//
// Ports:
//   clk          in   tile clock
//   reset_n      in   asynchronous active-low reset
//   rts_ready    in   [31:0] ready-to-send flags; bits >= NUM_PORTS ignored
//   running      in   device is in the running state; gates new grants
//   send_req     out  request to the send handler, held until send_ack
//   send_port    out  [PORT_IDX_WIDTH-1:0] granted port index
//   send_ack     in   send handler accepted the request
//   send_done    in   one-cycle pulse: send complete, device state written
//   busy         out  high whenever the scheduler is not idle
//   timeout_err  out  sticky flag, set when a send exceeds its time budget
//   sent_count   out  [31:0] number of completed sends (wrapping)
// ============================================================================
module dircc_rts_send_scheduler #(
    parameter int NUM_PORTS      = 32,
    parameter int PORT_IDX_WIDTH = 5,
    parameter int HOLDOFF_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               rts_ready,
    input  logic                      running,
    output logic                      send_req,
    output logic [PORT_IDX_WIDTH-1:0] send_port,
    input  logic                      send_ack,
    input  logic                      send_done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [31:0]               sent_count
);

    localparam int HOLD_WIDTH = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_WIDTH-1:0]     HOLD_LOAD  = HOLD_WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]  TIMER_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [PORT_IDX_WIDTH-1:0] LAST_PORT  = PORT_IDX_WIDTH'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLDOFF
    } state_t;

    state_t                      state;
    state_t                      state_n;
    logic                        send_req_n;
    logic [PORT_IDX_WIDTH-1:0]   send_port_n;
    logic [PORT_IDX_WIDTH-1:0]   rr_ptr;
    logic [PORT_IDX_WIDTH-1:0]   rr_ptr_n;
    logic [TIMEOUT_WIDTH-1:0]    timer;
    logic [TIMEOUT_WIDTH-1:0]    timer_n;
    logic [TIMEOUT_WIDTH-1:0]    timer_inc;
    logic [HOLD_WIDTH-1:0]       hold_cnt;
    logic [HOLD_WIDTH-1:0]       hold_n;
    logic                        timeout_err_n;
    logic [31:0]                 sent_count_n;

    logic [NUM_PORTS-1:0]        masked;
    logic                        grant_valid;
    logic [PORT_IDX_WIDTH-1:0]   grant;

    // Flags above NUM_PORTS are deliberately discarded.
    logic                        unused_rts_bits;

    assign masked          = rts_ready[NUM_PORTS-1:0];
    assign unused_rts_bits = ^rts_ready;

    // The timer saturates at its last value. If send_ack arrives exactly on
    // the final REQ cycle, the WAIT state still sees an expired timer and
    // aborts on its next cycle rather than running on indefinitely.
    assign timer_inc = (timer == TIMER_LAST) ? timer : timer + 1'b1;

    // Port index reached by stepping 'offset' places above 'base', wrapping
    // at NUM_PORTS back to zero.
    function automatic logic [PORT_IDX_WIDTH-1:0] wrap_idx(input int base, input int offset);
        int sum;
        sum = base + offset;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return PORT_IDX_WIDTH'(sum);
    endfunction

    // Round-robin search starting at rr_ptr. The loop runs from the
    // farthest candidate back towards rr_ptr, so the last hit written is the
    // nearest set flag at or above the pointer (with wrap-around).
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (masked[wrap_idx(int'(rr_ptr), i)]) begin
                grant_valid = 1'b1;
                grant       = wrap_idx(int'(rr_ptr), i);
            end
        end
    end

    // Next-state and next-output logic. Every register has its next value
    // computed here, so the state register below is a plain load.
    // A send leaves REQ/WAIT on its completion event or on timeout, and
    // always passes through HOLDOFF before rts_ready is looked at again.
    always_comb begin
        state_n       = state;
        send_req_n    = send_req;
        send_port_n   = send_port;
        rr_ptr_n      = rr_ptr;
        timer_n       = timer;
        hold_n        = hold_cnt;
        timeout_err_n = timeout_err;
        sent_count_n  = sent_count;

        case (state)
            ST_IDLE: begin
                if (running && grant_valid) begin
                    state_n     = ST_REQ;
                    send_req_n  = 1'b1;
                    send_port_n = grant;
                    timer_n     = '0;
                    rr_ptr_n    = (grant == LAST_PORT) ? '0 : grant + 1'b1;
                end
            end

            ST_REQ: begin
                if (send_ack) begin
                    send_req_n = 1'b0;
                    if (send_done) begin
                        state_n      = ST_HOLDOFF;
                        hold_n       = HOLD_LOAD;
                        sent_count_n = sent_count + 32'd1;
                    end else begin
                        state_n = ST_WAIT;
                        timer_n = timer_inc;
                    end
                end else if (timer == TIMER_LAST) begin
                    send_req_n    = 1'b0;
                    timeout_err_n = 1'b1;
                    state_n       = ST_HOLDOFF;
                    hold_n        = HOLD_LOAD;
                end else begin
                    timer_n = timer_inc;
                end
            end

            ST_WAIT: begin
                if (send_done) begin
                    state_n      = ST_HOLDOFF;
                    hold_n       = HOLD_LOAD;
                    sent_count_n = sent_count + 32'd1;
                end else if (timer == TIMER_LAST) begin
                    timeout_err_n = 1'b1;
                    state_n       = ST_HOLDOFF;
                    hold_n        = HOLD_LOAD;
                end else begin
                    timer_n = timer_inc;
                end
            end

            ST_HOLDOFF: begin
                if (hold_cnt == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end

            default: begin
                state_n    = ST_IDLE;
                send_req_n = 1'b0;
            end
        endcase
    end

    // State and output registers. busy is registered from the next state so
    // that it is high in exactly the cycles in which the state is not IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            send_req    <= 1'b0;
            send_port   <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
            sent_count  <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            send_req    <= send_req_n;
            send_port   <= send_port_n;
            rr_ptr      <= rr_ptr_n;
            timer       <= timer_n;
            hold_cnt    <= hold_n;
            timeout_err <= timeout_err_n;
            sent_count  <= sent_count_n;
            busy        <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dircc_rts_send_scheduler.sv
// ============================================================================
// tb_dircc_rts_send_scheduler
//
// Purpose:
//   Self-checking bench for dircc_rts_send_scheduler. The main instance has
//   32 ports and a 16-cycle timeout. A second instance has 4 ports and
//   confirms that flags above NUM_PORTS never produce a request. Expected
//   grant ports are queued when flags are driven and popped when send_req
//   appears.
// ============================================================================
module tb_dircc_rts_send_scheduler;

    logic        clk;
    logic        reset_n;
    logic [31:0] rts_ready;
    logic        running;
    logic        send_req;
    logic [4:0]  send_port;
    logic        send_ack;
    logic        send_done;
    logic        busy;
    logic        timeout_err;
    logic [31:0] sent_count;

    logic [31:0] rts4;
    logic        send_req4;
    logic [1:0]  send_port4;
    logic        send_ack4;
    logic        send_done4;
    logic        busy4;
    logic        timeout_err4;
    logic [31:0] sent_count4;

    typedef struct {
        logic [31:0] rts;
        int          ack_dly;
        int          done_dly;
        int          exp_port;
        int          exp_count;
    } vec_t;

    vec_t vecs[8];
    int   exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   lat;
    int   n;
    int   req_seen;
    int   busy_seen;

    int   dut4_req_cycles  = 0;
    int   dut4_busy_cycles = 0;
    bit   dut4_watch       = 1'b0;

    dircc_rts_send_scheduler #(
        .NUM_PORTS      (32),
        .PORT_IDX_WIDTH (5),
        .HOLDOFF_CYCLES (2),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_WIDTH  (16)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rts_ready   (rts_ready),
        .running     (running),
        .send_req    (send_req),
        .send_port   (send_port),
        .send_ack    (send_ack),
        .send_done   (send_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .sent_count  (sent_count)
    );

    dircc_rts_send_scheduler #(
        .NUM_PORTS      (4),
        .PORT_IDX_WIDTH (2),
        .HOLDOFF_CYCLES (2),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_WIDTH  (16)
    ) u_dut4 (
        .clk         (clk),
        .reset_n     (reset_n),
        .rts_ready   (rts4),
        .running     (running),
        .send_req    (send_req4),
        .send_port   (send_port4),
        .send_ack    (send_ack4),
        .send_done   (send_done4),
        .busy        (busy4),
        .timeout_err (timeout_err4),
        .sent_count  (sent_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulates any activity of the 4-port instance while it only sees
    // out-of-range flags.
    always @(negedge clk) begin
        if (dut4_watch) begin
            if (send_req4 === 1'b1) dut4_req_cycles++;
            if (busy4 === 1'b1) dut4_busy_cycles++;
        end
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        reset_n   = 1'b0;
        send_ack  = 1'b0;
        send_done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits at negedges for send_req, then compares send_port against the
    // oldest queued expectation. Returns the number of cycles waited, or -1
    // if the request never appeared.
    task automatic waitGrant(input string name, input int max_cycles, output int latency);
        int cnt;
        int exp_port;
        cnt = 0;
        while (send_req !== 1'b1 && cnt < max_cycles) begin
            @(negedge clk);
            cnt++;
        end
        if (send_req !== 1'b1) begin
            checks++;
            $display("[TB] FAIL %s: send_req not seen within %0d cycles", name, max_cycles);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            latency = -1;
        end else if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s: unexpected grant to port %0d", name, send_port);
            latency = cnt;
        end else begin
            exp_port = exp_q.pop_front();
            checkOutput(name, 32'(send_port), exp_port);
            latency = cnt;
        end
    endtask

    task automatic waitIdle(input string name);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // One complete transaction: drive flags, expect a grant, acknowledge
    // after ack_dly cycles, complete done_dly cycles after the ack (0 means
    // in the same cycle), then check the completed-send count.
    task automatic applyStimulus(input string name, input vec_t v);
        int latency;
        rts_ready = v.rts;
        running   = 1'b1;
        exp_q.push_back(v.exp_port);
        waitGrant({name, "_port"}, 40, latency);
        if (latency < 0) return;
        repeat (v.ack_dly) @(negedge clk);
        send_ack = 1'b1;
        if (v.done_dly == 0) send_done = 1'b1;
        @(negedge clk);
        send_ack  = 1'b0;
        send_done = 1'b0;
        checkOutput({name, "_req_drop"}, 32'(send_req), 32'd0);
        if (v.done_dly > 0) begin
            repeat (v.done_dly - 1) @(negedge clk);
            send_done = 1'b1;
            @(negedge clk);
            send_done = 1'b0;
        end
        checkOutput({name, "_count"}, sent_count, v.exp_count);
    endtask

    initial begin
        vecs[0] = '{32'h8000_0005, 0, 0, 0,  1};
        vecs[1] = '{32'h8000_0005, 0, 0, 2,  2};
        vecs[2] = '{32'h8000_0005, 0, 0, 31, 3};
        vecs[3] = '{32'h8000_0005, 0, 0, 0,  4};
        vecs[4] = '{32'h8000_0005, 0, 0, 2,  5};
        vecs[5] = '{32'h0001_0100, 2, 3, 8,  6};
        vecs[6] = '{32'h0001_0100, 1, 1, 16, 7};
        vecs[7] = '{32'h0000_0100, 0, 2, 8,  8};

        running    = 1'b0;
        rts_ready  = '0;
        rts4       = '0;
        send_ack   = 1'b0;
        send_done  = 1'b0;
        send_ack4  = 1'b0;
        send_done4 = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        checkOutput("rst_send_req",    32'(send_req),    32'd0);
        checkOutput("rst_send_port",   32'(send_port),   32'd0);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_sent_count",  sent_count,       32'd0);

        // Single send: flag at cycle 0, ack at +2, done at +4.
        $display("[TB] single send with ack/done spacing");
        rts4       = 32'h0000_00F0;
        dut4_watch = 1'b1;
        running    = 1'b1;
        rts_ready  = 32'h1;
        exp_q.push_back(0);
        waitGrant("t1_port", 8, lat);
        checkOutput("t1_latency", lat, 32'd1);
        checkOutput("t1_busy_req", 32'(busy), 32'd1);
        @(negedge clk);
        send_ack = 1'b1;
        @(negedge clk);
        send_ack = 1'b0;
        checkOutput("t1_req_drop", 32'(send_req), 32'd0);
        checkOutput("t1_busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
        send_done = 1'b1;
        @(negedge clk);
        send_done = 1'b0;
        rts_ready = '0;
        checkOutput("t1_count", sent_count, 32'd1);
        checkOutput("t1_busy_hold0", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t1_busy_hold1", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t1_busy_idle", 32'(busy), 32'd0);

        // Round-robin sequence from a clean pointer.
        $display("[TB] round-robin table");
        resetDut();
        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end
        rts_ready = '0;
        waitIdle("tbl_idle");

        // Timeout: no ack for the grant to port 5 (pointer now at 9).
        $display("[TB] timeout");
        rts_ready = 32'h0000_0020;
        exp_q.push_back(5);
        waitGrant("t5_port", 10, lat);
        rts_ready = '0;
        n = 0;
        while (send_req === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_req_cycles", n, 32'd16);
        checkOutput("t5_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t5_count_kept", sent_count, 32'd8);
        waitIdle("t5_idle");
        applyStimulus("t5_next", '{32'h0000_0080, 0, 1, 7, 9});
        rts_ready = '0;
        waitIdle("t5_next_idle");
        checkOutput("t5_err_sticky", 32'(timeout_err), 32'd1);

        // Stale flag for port 3 held one cycle after done is not regranted.
        $display("[TB] stale flag after done");
        rts_ready = 32'h0000_0008;
        exp_q.push_back(3);
        waitGrant("t4_port", 10, lat);
        send_ack  = 1'b1;
        send_done = 1'b1;
        @(negedge clk);
        send_ack  = 1'b0;
        send_done = 1'b0;
        @(negedge clk);
        rts_ready = '0;
        req_seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (send_req === 1'b1) req_seen++;
        end
        checkOutput("t4_no_regrant", req_seen, 32'd0);
        checkOutput("t4_count", sent_count, 32'd10);
        // Flag held through HOLDOFF is served again via pointer wrap.
        applyStimulus("t4_held_a", '{32'h0000_0008, 0, 0, 3, 11});
        applyStimulus("t4_held_b", '{32'h0000_0008, 0, 0, 3, 12});
        rts_ready = '0;
        waitIdle("t4_idle");

        // Asynchronous reset while in WAIT.
        $display("[TB] reset during WAIT");
        rts_ready = 32'h0000_0002;
        exp_q.push_back(1);
        waitGrant("t6_port", 10, lat);
        send_ack = 1'b1;
        @(negedge clk);
        send_ack  = 1'b0;
        rts_ready = '0;
        checkOutput("t6_busy_wait", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_send_req",  32'(send_req),    32'd0);
        checkOutput("t6_rst_send_port", 32'(send_port),   32'd0);
        checkOutput("t6_rst_busy",      32'(busy),        32'd0);
        checkOutput("t6_rst_err",       32'(timeout_err), 32'd0);
        checkOutput("t6_rst_count",     sent_count,       32'd0);
        @(negedge clk);
        running   = 1'b0;
        rts_ready = 32'hFFFF_FFFF;
        @(negedge clk);
        reset_n   = 1'b1;
        req_seen  = 0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (send_req === 1'b1) req_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        checkOutput("t6_not_running_req", req_seen, 32'd0);
        checkOutput("t6_not_running_busy", busy_seen, 32'd0);
        applyStimulus("t6_resume", '{32'hFFFF_FFFF, 0, 0, 0, 1});
        rts_ready = '0;
        waitIdle("t6_idle");

        // Four-port instance saw only out-of-range flags throughout.
        $display("[TB] masked upper flags");
        dut4_watch = 1'b0;
        checkOutput("t3_req_cycles", dut4_req_cycles, 32'd0);
        checkOutput("t3_busy_cycles", dut4_busy_cycles, 32'd0);
        running = 1'b1;
        rts4    = 32'h0000_0018;
        @(negedge clk);
        checkOutput("t3_valid_req", 32'(send_req4), 32'd1);
        checkOutput("t3_valid_port", 32'(send_port4), 32'd3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
